// File: rtl/dff_shift_reg.sv
// Multi-word register chain: hold / serial shift / parallel load / rotate, with saturating fill count.
// Latency: one edge per operation; a shifted-in word reaches Q after DEPTH shift edges.
// No backpressure: EN gates every MODE operation, CLR always wins, and all outputs are registered.
module dff_shift_reg #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic [1:0]             MODE,
    input  logic [WIDTH-1:0]       D,
    input  logic [WIDTH*DEPTH-1:0] P,
    output logic [WIDTH-1:0]       Q,
    output logic [WIDTH*DEPTH-1:0] QALL,
    output logic [CW-1:0]          CNT,
    output logic                   FULL
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

    // DEPTH always fits in CW bits, so comparing against it cannot overflow even when DEPTH = 2^n - 1.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [CW-1:0]               cnt_q, cnt_d;

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (CLR) begin
            stage_d = '0;
            cnt_d   = '0;
        end else if (EN) begin
            case (MODE)
                MODE_SHIFT: begin
                    stage_d = {stage_q[DEPTH-2:0], D};
                    cnt_d   = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CW'(1);
                end
                MODE_LOAD: begin
                    stage_d = P;
                    cnt_d   = DEPTH_C;
                end
                MODE_ROT: begin
                    stage_d = {stage_q[DEPTH-2:0], stage_q[DEPTH-1]};
                end
                default: begin
                    stage_d = stage_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q    = stage_q[DEPTH-1];
    assign QALL = stage_q;
    assign CNT  = cnt_q;
    assign FULL = (cnt_q == DEPTH_C);

endmodule

// File: tb/tb_dff_shift_reg.sv
// Scoreboard bench for dff_shift_reg (WIDTH=4, DEPTH=8): stimulus queues expected state, monitor compares.
module tb_dff_shift_reg;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int CW = 4;

    logic           CLK   = 1'b0;
    logic           RST_N = 1'b1;
    logic           EN    = 1'b0;
    logic           CLR   = 1'b0;
    logic [1:0]     MODE  = 2'b00;
    logic [W-1:0]   D     = '0;
    logic [W*N-1:0] P     = '0;
    logic [W-1:0]   Q;
    logic [W*N-1:0] QALL;
    logic [CW-1:0]  CNT;
    logic           FULL;

    dff_shift_reg #(.WIDTH(W), .DEPTH(N)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .EN   (EN),
        .CLR  (CLR),
        .MODE (MODE),
        .D    (D),
        .P    (P),
        .Q    (Q),
        .QALL (QALL),
        .CNT  (CNT),
        .FULL (FULL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0]   q;
        logic [W*N-1:0] qall;
        logic [CW-1:0]  cnt;
        logic           full;
    } obs_t;

    obs_t  exp_fifo[$];
    string name_fifo[$];
    int    tests = 0;
    int    fails = 0;

    task automatic push_exp(input string nm, input logic [W*N-1:0] eqall,
                            input logic [CW-1:0] ecnt, input logic efull);
        obs_t e;
        e.qall = eqall;
        e.q    = eqall[W*N-1 -: W];
        e.cnt  = ecnt;
        e.full = efull;
        exp_fifo.push_back(e);
        name_fifo.push_back(nm);
    endtask

    // One clock edge with the given inputs; expected post-edge state goes to the scoreboard.
    task automatic step(input string nm, input logic en, input logic clr, input logic [1:0] mode,
                        input logic [W-1:0] d, input logic [W*N-1:0] p,
                        input logic [W*N-1:0] eqall, input logic [CW-1:0] ecnt, input logic efull);
        EN = en; CLR = clr; MODE = mode; D = d; P = p;
        @(posedge CLK);
        #1;
        push_exp(nm, eqall, ecnt, efull);
        @(negedge CLK);
    endtask

    // Monitor: samples away from the rising edge, and right after any reset assertion.
    initial begin
        obs_t  e;
        obs_t  got;
        string nm;
        forever begin
            @(negedge CLK or negedge RST_N);
            #1;
            if (exp_fifo.size() > 0) begin
                e   = exp_fifo.pop_front();
                nm  = name_fifo.pop_front();
                got = {Q, QALL, CNT, FULL};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: got Q=%h QALL=%h CNT=%0d FULL=%b, expected Q=%h QALL=%h CNT=%0d FULL=%b",
                             nm, got.q, got.qall, got.cnt, got.full, e.q, e.qall, e.cnt, e.full);
                end
            end
        end
    end

    logic [W*N-1:0] shift_exp [N] = '{32'h00000001, 32'h00000012, 32'h00000123, 32'h00001234,
                                      32'h00012345, 32'h00123456, 32'h01234567, 32'h12345678};
    logic [W*N-1:0] rot_exp [N]   = '{32'h65432107, 32'h54321076, 32'h43210765, 32'h32107654,
                                      32'h21076543, 32'h10765432, 32'h07654321, 32'h76543210};
    logic [W-1:0]   part_d [3]    = '{4'hA, 4'hB, 4'hC};
    logic [W*N-1:0] part_exp [3]  = '{32'h0000000A, 32'h000000AB, 32'h00000ABC};

    initial begin
        // Power-on reset, checked while RST_N is still low.
        #2;
        push_exp("reset_async", '0, '0, 1'b0);
        RST_N = 1'b0;
        @(negedge CLK);
        #2 RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 3; i++)
            step($sformatf("hold_en0_%0d", i), 1'b0, 1'b0, 2'b01, 4'hF, '0, '0, '0, 1'b0);

        for (int i = 0; i < N; i++)
            step($sformatf("shift_%0d", i + 1), 1'b1, 1'b0, 2'b01, W'(i + 1), '0,
                 shift_exp[i], CW'(i + 1), (i == N - 1));
        step("shift_full_sat", 1'b1, 1'b0, 2'b01, 4'h9, '0, 32'h23456789, 4'd8, 1'b1);

        step("load", 1'b1, 1'b0, 2'b10, 4'h0, 32'h76543210, 32'h76543210, 4'd8, 1'b1);
        step("hold_full_en0", 1'b0, 1'b0, 2'b01, 4'hF, 32'hFFFFFFFF, 32'h76543210, 4'd8, 1'b1);
        step("hold_mode00", 1'b1, 1'b0, 2'b00, 4'hF, 32'hFFFFFFFF, 32'h76543210, 4'd8, 1'b1);

        for (int i = 0; i < N; i++)
            step($sformatf("rotate_%0d", i + 1), 1'b1, 1'b0, 2'b11, 4'hF, '0, rot_exp[i], 4'd8, 1'b1);

        step("clr_en0", 1'b0, 1'b1, 2'b01, 4'hF, '0, '0, '0, 1'b0);
        step("reload", 1'b1, 1'b0, 2'b10, 4'h0, 32'h76543210, 32'h76543210, 4'd8, 1'b1);
        step("clr_over_load", 1'b1, 1'b1, 2'b10, 4'h0, 32'hFFFFFFFF, '0, '0, 1'b0);

        for (int i = 0; i < 3; i++)
            step($sformatf("partial_%0d", i + 1), 1'b1, 1'b0, 2'b01, part_d[i], '0,
                 part_exp[i], CW'(i + 1), 1'b0);
        step("rotate_partial", 1'b1, 1'b0, 2'b11, 4'h0, '0, 32'h0000ABC0, 4'd3, 1'b0);

        step("clr_before_stream", 1'b0, 1'b1, 2'b00, 4'h0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            step($sformatf("stream_%0d", i + 1), 1'b1, 1'b0, 2'b01, W'(i + 1), '0,
                 shift_exp[i], CW'(i + 1), 1'b0);

        // Reset pulse between shift edges 4 and 5, released before the next rising edge.
        EN = 1'b0;
        #2;
        push_exp("reset_mid_stream", '0, '0, 1'b0);
        RST_N = 1'b0;
        #2 RST_N = 1'b1;
        @(negedge CLK);

        step("resume_1", 1'b1, 1'b0, 2'b01, 4'h5, '0, 32'h00000005, 4'd1, 1'b0);
        step("resume_2", 1'b1, 1'b0, 2'b01, 4'h6, '0, 32'h00000056, 4'd2, 1'b0);

        EN = 1'b0;
        for (int i = 0; i < 10 && exp_fifo.size() > 0; i++)
            @(negedge CLK);
        #2;
        if (exp_fifo.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_fifo.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_shift_reg.md
Name: dff_shift_reg

Overview:
Parametrised multi-word register chain: the next generation of the single-bit dff cell. It holds DEPTH words of WIDTH bits and supports hold, serial shift, parallel load and rotate modes, plus a synchronous clear. It also keeps a saturating fill count and a FULL flag. It serves as the generic delay line, serialiser and deserialiser storage element in the datapath.

Parameters:
WIDTH, 4, bits per word (>=1)
DEPTH, 8, number of word stages (>=2)
CW, $clog2(DEPTH+1), width of CNT (derived localparam, not overridable)

Ports:
CLK    input   1              clock, all state updates on rising edge
RST_N  input   1              asynchronous active-low reset
EN     input   1              enable for MODE operations; CLR is not gated by EN
CLR    input   1              synchronous clear, highest priority
MODE   input   2              00 hold, 01 shift, 10 parallel load, 11 rotate
D      input   WIDTH          serial word in (shift mode)
P      input   WIDTH*DEPTH    parallel load data; stage i = P[i*WIDTH +: WIDTH]
Q      output  WIDTH          last stage, stage[DEPTH-1]
QALL   output  WIDTH*DEPTH    all stages, packed as P
CNT    output  CW             number of valid words held, 0..DEPTH
FULL   output  1              CNT == DEPTH

Behaviour:
- Reset: RST_N low asynchronously forces all stages to 0 and CNT to 0. Q=0, QALL=0, CNT=0, FULL=0 while RST_N is low. Release is synchronous to the next CLK edge.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. The operation in flight is lost.
- Priority per rising edge: CLR > (EN & MODE) > hold.
- CLR=1: all stages <= 0 and CNT <= 0, regardless of EN and MODE.
- EN=0 (and CLR=0): full hold. MODE, D and P are ignored.
- MODE=00: hold.
- MODE=01 (shift):
  - stage[0] <= D; stage[i] <= stage[i-1] for i=1..DEPTH-1; old stage[DEPTH-1] is discarded.
  - CNT <= min(CNT+1, DEPTH), saturating with no wrap.
- MODE=10 (load): stage[i] <= P[i*WIDTH +: WIDTH] for all i; CNT <= DEPTH.
- MODE=11 (rotate):
  - stage[0] <= stage[DEPTH-1]; stage[i] <= stage[i-1].
  - CNT unchanged.
- Latency: a word shifted in at edge k appears on Q after DEPTH shift edges. Hold cycles between shifts do not advance it.
- All outputs come directly from registers (CNT compare for FULL is the only logic). There is no combinational path from any input to any output.
- FULL asserts in the cycle after the edge on which CNT reaches DEPTH.
- Shift while FULL: data still advances, CNT stays at DEPTH.
- Rotate with CNT<DEPTH: zero or stale stages rotate too. CNT is not recomputed.
- Widths: CNT is exactly CW bits. The saturation compare must not overflow for DEPTH = 2^n - 1.
- Structure: one always block per stage array plus the counter, using nonblocking assignments. The design is synthesisable to dff cells plus muxing.

Test Plan:
- Reset and hold (WIDTH=4, DEPTH=8):
  - Pulse RST_N low mid-clock-cycle -> Q=0, QALL=0, CNT=0, FULL=0 immediately.
  - Then EN=0 with MODE=01, D=F for 3 edges -> all outputs unchanged.
- Shift latency: EN=1, MODE=01, D=1,2,...,8 on 8 edges -> after edge 8: Q=1, QALL=0x12345678 (stage7..stage0), CNT=8, FULL=1.
  - One more shift with D=9 -> Q=2, CNT stays 8.
- Load and rotate:
  - MODE=10, P=0x76543210 -> next cycle QALL=0x76543210, Q=7, CNT=8.
  - Then MODE=11 for 1 edge -> QALL=0x65432107, Q=6.
  - 8 rotate edges total -> QALL back to 0x76543210, CNT=8.
- Clear priority:
  - From full state, CLR=1 with EN=0 -> QALL=0, CNT=0, FULL=0 next cycle.
  - CLR=1 with EN=1, MODE=10 -> still cleared; load is ignored.
- Partial fill: 3 shifts D=A,B,C -> CNT=3, FULL=0, QALL=0x00000ABC, Q=0.
- Reset during shift stream: assert RST_N low between edges 4 and 5 of a shift sequence -> all state 0 at once.
  - Resume after release: shifts restart with CNT counting from 0.
